// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words into instruction memory
// and holds the CPU in reset until the image is in. Define PROG_LOADER_CSUM_EN for a trailing XOR checksum byte.
module prog_loader #(
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
  parameter int unsigned           DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef PROG_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              xfer;
  logic [15:0]       hdr_len;
  logic              last_word;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    s_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA)
`ifdef PROG_LOADER_CSUM_EN
              || (state_q == S_CSUM)
`endif
              ;
  end

  assign xfer      = s_valid && s_ready;
  assign hdr_len   = {s_data, len_q[7:0]};
  assign last_word = (16'(idx_q + 16'd1) == len_q);

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef PROG_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef PROG_LOADER_CSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = s_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = s_data;
          if ({1'b0, hdr_len} > DEPTH_L) begin
            state_d = S_ERROR;
          end else if (hdr_len == 16'd0) begin
`ifdef PROG_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = s_data;
            2'd1: word_d[15:8]  = s_data;
            2'd2: word_d[23:16] = s_data;
            default: begin
              // Address and data are latched here so they hold steady through WRITE and after it.
              wdata_d = {s_data, word_q};
              addr_d  = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = (s_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef PROG_LOADER_CSUM_EN
    // The checksum byte itself is compared, never folded in.
    if (xfer && (state_q != S_CSUM)) begin
      csum_d = csum_q ^ s_data;
    end
`endif

    cpu_rst_d = (state_d != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 0x0 and 0x100) share one byte stream.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready0, s_ready1;
  logic        mem_we0, mem_we1;
  logic [31:0] mem_addr0, mem_addr1;
  logic [31:0] mem_wdata0, mem_wdata1;
  logic        cpu_rst0, cpu_rst1;
  logic        done0, done1;
  logic        error0, error1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_xfer = 0;
  logic prev_we = 1'b0;
  logic [31:0] log0_addr[$], log0_data[$], log1_addr[$], log1_data[$];

  prog_loader #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .DEPTH(1024)) dut0 (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_rst(cpu_rst0), .done(done0), .error(error0)
  );

  prog_loader #(.ADDR_W(32), .BASE_ADDR(32'h0000_0100), .DEPTH(1024)) dut1 (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_rst(cpu_rst1), .done(done1), .error(error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: logs both instances and checks strobe shape on dut0.
  always @(negedge clk) begin
    if (mem_we0) begin
      check("we_one_cycle", 32'(prev_we), 32'd0);
      check("ready_low_in_write", 32'(s_ready0), 32'd0);
      check("we_latency", 32'(cyc - last_xfer), 32'd0);
      log0_addr.push_back(mem_addr0);
      log0_data.push_back(mem_wdata0);
    end
    if (mem_we1) begin
      log1_addr.push_back(mem_addr1);
      log1_data.push_back(mem_wdata1);
    end
    prev_we = mem_we0;
  end

  task automatic clear_logs();
    log0_addr.delete(); log0_data.delete();
    log1_addr.delete(); log1_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  n    = 0;
    bit  sent = 1'b0;
    s_data = b;
    while (!sent && n < 100) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      sent = s_valid && s_ready0;
      @(posedge clk);
      #1;
      if (sent) last_xfer = cyc;
      n++;
    end
    s_valid = 1'b0;
    check("byte_accepted", 32'(sent), 32'd1);
  endtask

  task automatic send_seq(input byte_q_t bytes, input bit rnd);
    foreach (bytes[i]) send_byte(bytes[i], rnd);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called in the WRITE cycle of the last word; ends with the loader in DONE/ERROR.
  task automatic finish_image(input logic [7:0] csum, input bit rnd);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(csum, rnd);
`else
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic check_log(input string tag, input int n, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] words[2];
    words[0] = w0;
    words[1] = w1;
    check({tag, "_n0"}, 32'(log0_addr.size()), 32'(n));
    check({tag, "_n1"}, 32'(log1_addr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log0_addr.size() && i < log1_addr.size()) begin
        check({tag, "_addr0"}, log0_addr[i], 32'(4 * i));
        check({tag, "_data0"}, log0_data[i], words[i]);
        check({tag, "_addr1"}, log1_addr[i], 32'h100 + 32'(4 * i));
        check({tag, "_data1"}, log1_data[i], words[i]);
      end
    end
  endtask

  byte_q_t img;

  initial begin
    rst = 1'b0; start = 1'b0; s_data = 8'h00; s_valid = 1'b0;
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst0), 32'd1);
    check("rst_s_ready", 32'(s_ready0), 32'd0);
    check("rst_mem_we", 32'(mem_we0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_error", 32'(error0), 32'd0);
    check("rst_addr0", mem_addr0, 32'h0);
    check("rst_addr1", mem_addr1, 32'h100);
    check("rst_wdata", mem_wdata0, 32'h0);
    @(posedge clk);
    #1;

    // Two-word image, s_valid held high
    clear_logs();
    pulse_start();
    check("start_s_ready", 32'(s_ready0), 32'd1);
    send_seq(img, 1'b0);
    @(negedge clk);
    check("last_write_we", 32'(mem_we0), 32'd1);
    check("last_write_done", 32'(done0), 32'd0);
    check("last_write_cpu_rst", 32'(cpu_rst0), 32'd1);
    finish_image(8'hDB, 1'b0);
    check("img_done", 32'(done0), 32'd1);
    check("img_cpu_rst", 32'(cpu_rst0), 32'd0);
    check("img_error", 32'(error0), 32'd0);
    check("img_hold_addr", mem_addr0, 32'h4);
    check("img_hold_wdata", mem_wdata0, 32'h0000_006F);
    check("img_hold_we", 32'(mem_we0), 32'd0);
    check_log("img", 2, 32'h00A0_0513, 32'h0000_006F);

    // Restart from DONE, random s_valid
    clear_logs();
    pulse_start();
    check("restart_done_clr", 32'(done0), 32'd0);
    check("restart_cpu_rst", 32'(cpu_rst0), 32'd1);
    send_seq(img, 1'b1);
    @(negedge clk);
    finish_image(8'hDB, 1'b1);
    check("rnd_done", 32'(done0), 32'd1);
    check("rnd_done1", 32'(done1), 32'd1);
    check_log("rnd", 2, 32'h00A0_0513, 32'h0000_006F);

    // Length 1025 is rejected right after the header
    clear_logs();
    pulse_start();
    send_seq('{8'h01, 8'h04}, 1'b0);
    check("big_error", 32'(error0), 32'd1);
    check("big_cpu_rst", 32'(cpu_rst0), 32'd1);
    check("big_done", 32'(done0), 32'd0);
    check("big_s_ready", 32'(s_ready0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("big_error_hold", 32'(error0), 32'd1);
    check_log("big", 0, 32'h0, 32'h0);

    // Zero-length image, started from ERROR
    pulse_start();
    check("zero_error_clr", 32'(error0), 32'd0);
    send_seq('{8'h00, 8'h00}, 1'b0);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    check("zero_done", 32'(done0), 32'd1);
    check("zero_cpu_rst", 32'(cpu_rst0), 32'd0);
    check_log("zero", 0, 32'h0, 32'h0);

    // Reset mid-load after six data bytes
    clear_logs();
    pulse_start();
    send_seq('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00}, 1'b0);
    check("mid_s_ready", 32'(s_ready0), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_s_ready", 32'(s_ready0), 32'd0);
    check("async_cpu_rst", 32'(cpu_rst0), 32'd1);
    check("async_wdata", mem_wdata0, 32'h0);
    check("async_done", 32'(done0), 32'd0);
    check_log("mid", 1, 32'h00A0_0513, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Full reload; a start pulse inside DATA must be ignored
    clear_logs();
    pulse_start();
    send_seq('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0}, 1'b0);
    pulse_start();
    send_seq('{8'h00, 8'h6F, 8'h00, 8'h00, 8'h00}, 1'b0);
    @(negedge clk);
    finish_image(8'hDB, 1'b0);
    check("reload_done", 32'(done0), 32'd1);
    check_log("reload", 2, 32'h00A0_0513, 32'h0000_006F);

`ifdef PROG_LOADER_CSUM_EN
    // Checksum good, then checksum bad
    clear_logs();
    pulse_start();
    send_seq('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00}, 1'b0);
    @(negedge clk);
    send_byte(8'hB7, 1'b0);
    check("csum_ok_done", 32'(done0), 32'd1);
    check("csum_ok_error", 32'(error0), 32'd0);
    check_log("csum_ok", 1, 32'h00A0_0513, 32'h0);
    clear_logs();
    pulse_start();
    send_seq('{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00}, 1'b0);
    @(negedge clk);
    send_byte(8'hB6, 1'b0);
    check("csum_bad_error", 32'(error0), 32'd1);
    check("csum_bad_done", 32'(done0), 32'd0);
    check("csum_bad_cpu_rst", 32'(cpu_rst0), 32'd1);
    check_log("csum_bad", 1, 32'h00A0_0513, 32'h0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU's instruction-fetch path: receives a byte stream and assembles little-endian 32-bit words.
- Writes each assembled word into instruction ROM/RAM through a simple write port.
- Holds the CPU in reset (via its active-high rst) until the image is fully loaded.
- Sits between a host byte source (UART RX or bench) and the PC_ROM write port.

Parameters:
- ADDR_W, 32, width of mem_addr (byte address).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.
- DEPTH, 1024, maximum number of words accepted; a larger header count is an error.

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- rst, input, 1, one clock; reset is asynchronous and active-low.
- start, input, 1, single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- s_data, input, 8, stream byte.
- s_valid, input, 1, s_data valid.
- s_ready, output, 1, loader can accept a byte this cycle.
- mem_we, output, 1, one-cycle write strobe to instruction memory.
- mem_addr, output, ADDR_W, word-aligned byte address of the write.
- mem_wdata, output, 32, word being written.
- cpu_rst, output, 1, active-high reset to the CPU; high while not DONE.
- done, output, 1, image loaded; level.
- error, output, 1, load aborted; level.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cpu_rst=1, s_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, error=0; word index, byte count and length cleared.
- Byte handshake: a byte transfers on a rising edge with s_valid&&s_ready. s_ready is registered-state decoded: 1 only in LEN_LO, LEN_HI, DATA and CSUM. s_data is ignored when no transfer occurs.
- IDLE: start=1 -> LEN_LO. Other inputs ignored.
- LEN_LO: byte -> len[7:0]; go to LEN_HI.
- LEN_HI: byte -> len[15:8], then:
  - len > DEPTH -> ERROR.
  - len == 0 -> CSUM if the optional feature is enabled, else DONE.
  - otherwise -> DATA.
- DATA: bytes k=0..3 fill word[8k+7:8k]. The transfer of byte 3 moves to WRITE.
- WRITE: lasts exactly 1 cycle; s_ready=0; mem_we=1; mem_addr=BASE_ADDR+4*idx (mod 2^ADDR_W); mem_wdata=assembled word. Next edge: idx++, then:
  - idx+1 == len -> CSUM if enabled, else DONE.
  - otherwise -> DATA.
- Latency: mem_we asserts in the cycle after the 4th byte's transfer edge. Peak throughput is 4 bytes per 5 cycles.
- mem_addr and mem_wdata hold their last value outside WRITE; mem_we=0 outside WRITE.
- DONE: done=1, cpu_rst=0. Stays until start or rst.
- ERROR: error=1, cpu_rst=1. Stays until start or rst.
- start in DONE or ERROR -> LEN_LO on the next edge:
  - done and error clear; cpu_rst=1 from that edge; idx and byte count cleared.
- start in any loading state (LEN_LO..CSUM) is ignored.
- Asynchronous reset mid-load aborts immediately. Words already written stay in memory; no partial word is written.
- cpu_rst is registered, glitch-free, and deasserts on the same edge that enters DONE.

Optional Feature:
- Macro PROG_LOADER_CSUM_EN.
- Defined:
  - A running XOR checksum covers every accepted byte, including both length bytes.
  - State CSUM accepts one extra byte. If it equals the running XOR -> DONE, else -> ERROR.
  - The memory writes already performed are not undone.
- Undefined: CSUM state and checksum register are absent; the last WRITE (or a zero len) goes straight to DONE.

Test Plan:
- Reset, then idle 5 cycles -> cpu_rst=1, s_ready=0, mem_we=0, done=0, error=0. Assert rst=0 mid-cycle -> outputs return to reset values without waiting for a clock edge.
- start, then stream 02 00 | 13 05 A0 00 | 6F 00 00 00 with s_valid held high (feature off) -> two writes:
  - mem_addr=0x0, mem_wdata=0x00A00513.
  - mem_addr=0x4, mem_wdata=0x0000006F.
  - Each mem_we is 1 cycle, the cycle after the 4th byte. done=1 and cpu_rst=0 on the edge after the second WRITE.
- Same image with s_valid toggled randomly and BASE_ADDR=0x100 -> identical data at 0x100 and 0x104. No byte is lost or duplicated. s_ready=0 exactly in the WRITE cycles.
- Header length out of range:
  - Header 01 04 (len=1025) -> ERROR after the 2nd byte; error=1, cpu_rst=1, no mem_we.
  - Header 00 00 -> DONE after the 2nd byte, no mem_we.
- Mid-load recovery: rst pulsed low after 6 data bytes -> only the first word has been written. Next start plus a full stream then loads correctly. start pulsed during DATA has no effect.
- With PROG_LOADER_CSUM_EN, image 01 00 | 13 05 A0 00:
  - Trailing byte B7 (XOR of the six bytes) -> done=1.
  - Trailing byte B6 -> error=1, cpu_rst stays 1; the write to 0x0 has still occurred.
